fir_engine_param: RTL and testbench

Parametrised successor to the 11-tap FIR accelerator. Coefficients and length are programmed over AXI-Lite, samples stream in over AXI-Stream, and filtered results stream out. Generalised in tap count, data width and runtime tap length, with optional output saturation. Taps and sample history live in internal registers; one shared MAC performs one multiply per cycle. The block sits behind the SoC AXI-Lite interconnect, between the stream DMA source and sink.

---
 rtl/fir_engine_param.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_fir_engine_param.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_engine_param.sv
// -----------------------------------------------------------------------------
// fir_engine_param
//   Parametrised streaming FIR engine. Coefficients, tap count and job length
//   are programmed over AXI-Lite. Samples arrive on an AXI-Stream slave and
//   filtered results leave on an AXI-Stream master. A single shared MAC
//   performs one multiply per cycle.
//
// Parameters
//   DATA_W  : sample / coefficient / AXI data width
//   ADDR_W  : AXI-Lite address width
//   MAX_TAP : number of tap and history registers (1..32)
//
// Ports
//   axis_clk, axis_rst_n          : clock, asynchronous active-low reset
//   aw*/w*                        : AXI-Lite write address / data (no response channel)
//   ar*/r*                        : AXI-Lite read address / data
//   ss_tvalid/ss_tready/ss_tdata  : input sample stream (ss_tlast ignored)
//   sm_tvalid/sm_tready/sm_tdata/sm_tlast : output result stream
//
// Register map
//   0x00 ap_ctrl  {idle, done, start/busy}
//   0x10 data_length
//   0x14 ntap (clamped to 1..MAX_TAP)
//   0x20+4k tap h[k]
//
// Build option
//   FIR_SATURATE_EN : when defined, results are clamped to the signed DATA_W
//                     range instead of wrapping.
// -----------------------------------------------------------------------------
module fir_engine_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int MAX_TAP = 16
) (
    input  logic              axis_clk,
    input  logic              axis_rst_n,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    input  logic              ss_tvalid,
    output logic              ss_tready,
    input  logic [DATA_W-1:0] ss_tdata,
    input  logic              ss_tlast,
    output logic              sm_tvalid,
    input  logic              sm_tready,
    output logic [DATA_W-1:0] sm_tdata,
    output logic              sm_tlast
);

    localparam int KW    = (MAX_TAP > 1) ? $clog2(MAX_TAP) : 1;
    localparam int NW    = $clog2(MAX_TAP + 1);
    localparam int ACC_W = 2 * DATA_W + $clog2(MAX_TAP);

    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(32'h0000_0000);
    localparam logic [ADDR_W-1:0] A_LEN  = ADDR_W'(32'h0000_0010);
    localparam logic [ADDR_W-1:0] A_NTAP = ADDR_W'(32'h0000_0014);
    localparam logic [ADDR_W-1:0] A_TAP0 = ADDR_W'(32'h0000_0020);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_IN = 2'd1,
        S_MAC     = 2'd2,
        S_OUT     = 2'd3
    } state_t;

    state_t state_r, state_nx;

    logic                     awready_r, wready_r, arready_r, rvalid_r;
    logic [DATA_W-1:0]        rdata_r;
    logic                     ss_tready_r, sm_tvalid_r, sm_tlast_r;
    logic [DATA_W-1:0]        sm_tdata_r;
    logic                     ss_tready_nx, sm_tvalid_nx;
    logic                     done_r;
    logic [DATA_W-1:0]        data_len_r;
    logic [NW-1:0]            ntap_r;
    logic signed [DATA_W-1:0] h_r [MAX_TAP];
    logic signed [DATA_W-1:0] x_r [MAX_TAP];
    logic signed [ACC_W-1:0]  acc_r;
    logic [KW-1:0]            k_r;
    logic [DATA_W-1:0]        out_cnt_r;

    logic                       wr_fire_s, rd_fire_s, idle_s, wr_cfg_s;
    logic                       start_any_s, start_s, accept_s, mac_last_s;
    logic                       out_fire_s, last_out_s;
    logic [ADDR_W-1:0]          wofs_s, rofs_s;
    logic                       wr_tap_hit_s, rd_tap_hit_s;
    logic [KW-1:0]              wr_tap_idx_s, rd_tap_idx_s;
    logic [NW-1:0]              ntap_wr_s;
    logic [DATA_W-1:0]          rd_data_s;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    acc_sum_s;
    logic [DATA_W-1:0]          out_val_s;
    logic                       unused_s;

    assign awready   = awready_r;
    assign wready    = wready_r;
    assign arready   = arready_r;
    assign rvalid    = rvalid_r;
    assign rdata     = rdata_r;
    assign ss_tready = ss_tready_r;
    assign sm_tvalid = sm_tvalid_r;
    assign sm_tdata  = sm_tdata_r;
    assign sm_tlast  = sm_tlast_r;

    // The write handshake completes on the edge where both readies are high.
    assign wr_fire_s   = awvalid & wvalid & awready_r & wready_r;
    assign rd_fire_s   = arvalid & arready_r;
    assign idle_s      = (state_r == S_IDLE);
    assign wr_cfg_s    = wr_fire_s & idle_s;
    assign start_any_s = wr_fire_s & idle_s & (awaddr == A_CTRL) & wdata[0];
    assign start_s     = start_any_s & (data_len_r != '0);
    assign accept_s    = (state_r == S_WAIT_IN) & ss_tvalid;
    assign mac_last_s  = (state_r == S_MAC) & (NW'(k_r) == (ntap_r - NW'(1)));
    assign out_fire_s  = sm_tvalid_r & sm_tready;
    assign last_out_s  = (out_cnt_r == (data_len_r - DATA_W'(1)));

    // Tap window decode: word-aligned addresses inside 0x20 .. 0x20+4*MAX_TAP.
    assign wofs_s       = awaddr - A_TAP0;
    assign rofs_s       = araddr - A_TAP0;
    assign wr_tap_hit_s = (awaddr >= A_TAP0) && (awaddr[1:0] == 2'b00) &&
                          (wofs_s[ADDR_W-1:2] < (ADDR_W-2)'(MAX_TAP));
    assign rd_tap_hit_s = (araddr >= A_TAP0) && (araddr[1:0] == 2'b00) &&
                          (rofs_s[ADDR_W-1:2] < (ADDR_W-2)'(MAX_TAP));
    assign wr_tap_idx_s = wofs_s[KW+1:2];
    assign rd_tap_idx_s = rofs_s[KW+1:2];

    assign unused_s = ^{ss_tlast, wofs_s[1:0], rofs_s[1:0]};

    // Shared MAC: product sign-extended into the wide accumulator.
    assign prod_s    = h_r[k_r] * x_r[k_r];
    assign acc_sum_s = acc_r + ACC_W'(prod_s);

`ifdef FIR_SATURATE_EN
    function automatic logic [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-DATA_W:0] hi;
        hi = a[ACC_W-1:DATA_W-1];
        if ((&hi) || !(|hi)) begin
            sat_out = a[DATA_W-1:0];
        end else if (a[ACC_W-1]) begin
            sat_out = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_out = {1'b0, {(DATA_W-1){1'b1}}};
        end
    endfunction
    assign out_val_s = sat_out(acc_sum_s);
`else
    assign out_val_s = acc_sum_s[DATA_W-1:0];
`endif

    // Clamp an ntap write into 1..MAX_TAP.
    always_comb begin
        ntap_wr_s = NW'(MAX_TAP);
        if (wdata == '0) begin
            ntap_wr_s = NW'(1);
        end else if (wdata > DATA_W'(MAX_TAP)) begin
            ntap_wr_s = NW'(MAX_TAP);
        end else begin
            ntap_wr_s = wdata[NW-1:0];
        end
    end

    // Read data mux; unmapped addresses return zero.
    always_comb begin
        rd_data_s = '0;
        case (araddr)
            A_CTRL:  rd_data_s = DATA_W'({idle_s, done_r, ~idle_s});
            A_LEN:   rd_data_s = data_len_r;
            A_NTAP:  rd_data_s = DATA_W'(ntap_r);
            default: begin
                if (rd_tap_hit_s) begin
                    rd_data_s = h_r[rd_tap_idx_s];
                end else begin
                    rd_data_s = '0;
                end
            end
        endcase
    end

    // AXI-Lite handshake registers; one-cycle ready pulses, rvalid held until rready.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
        end else begin
            awready_r <= awvalid & wvalid & ~awready_r;
            wready_r  <= awvalid & wvalid & ~awready_r;
            arready_r <= arvalid & ~rvalid_r & ~arready_r;
            if (rd_fire_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_data_s;
            end else if (rvalid_r && rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // Configuration registers and the sticky done flag.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            data_len_r <= '0;
            ntap_r     <= NW'(MAX_TAP);
            done_r     <= 1'b0;
            for (int i = 0; i < MAX_TAP; i++) begin
                h_r[i] <= '0;
            end
        end else begin
            if (wr_cfg_s && (awaddr == A_LEN)) begin
                data_len_r <= wdata;
            end
            if (wr_cfg_s && (awaddr == A_NTAP)) begin
                ntap_r <= ntap_wr_s;
            end
            if (wr_cfg_s && wr_tap_hit_s) begin
                h_r[wr_tap_idx_s] <= wdata;
            end
            // Later assignments take priority: read-clear < start < final output.
            if (rd_fire_s && (araddr == A_CTRL)) begin
                done_r <= 1'b0;
            end
            if (start_any_s) begin
                done_r <= (data_len_r == '0);
            end
            if (out_fire_s && last_out_s) begin
                done_r <= 1'b1;
            end
        end
    end

    // FSM state register together with the registered stream handshake outputs.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_r     <= S_IDLE;
            ss_tready_r <= 1'b0;
            sm_tvalid_r <= 1'b0;
        end else begin
            state_r     <= state_nx;
            ss_tready_r <= ss_tready_nx;
            sm_tvalid_r <= sm_tvalid_nx;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) state_nx = S_WAIT_IN;
                else         state_nx = S_IDLE;
            end
            S_WAIT_IN: begin
                if (ss_tvalid) state_nx = S_MAC;
                else           state_nx = S_WAIT_IN;
            end
            S_MAC: begin
                if (mac_last_s) state_nx = S_OUT;
                else            state_nx = S_MAC;
            end
            S_OUT: begin
                if (sm_tready) begin
                    if (last_out_s) state_nx = S_IDLE;
                    else            state_nx = S_WAIT_IN;
                end else begin
                    state_nx = S_OUT;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so the registered copies track the state.
    always_comb begin
        ss_tready_nx = 1'b0;
        sm_tvalid_nx = 1'b0;
        case (state_nx)
            S_WAIT_IN: ss_tready_nx = 1'b1;
            S_OUT:     sm_tvalid_nx = 1'b1;
            default: begin
                ss_tready_nx = 1'b0;
                sm_tvalid_nx = 1'b0;
            end
        endcase
    end

    // Datapath: history shift, MAC accumulation, output capture and sample count.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            acc_r      <= '0;
            k_r        <= '0;
            out_cnt_r  <= '0;
            sm_tdata_r <= '0;
            sm_tlast_r <= 1'b0;
            for (int i = 0; i < MAX_TAP; i++) begin
                x_r[i] <= '0;
            end
        end else begin
            if (start_s) begin
                out_cnt_r <= '0;
                for (int i = 0; i < MAX_TAP; i++) begin
                    x_r[i] <= '0;
                end
            end else if (accept_s) begin
                x_r[0] <= ss_tdata;
                for (int i = 1; i < MAX_TAP; i++) begin
                    x_r[i] <= x_r[i-1];
                end
                acc_r <= '0;
                k_r   <= '0;
            end else if (state_r == S_MAC) begin
                acc_r <= acc_sum_s;
                k_r   <= k_r + KW'(1);
                // Capture the final sum directly so the output holds during stalls.
                if (mac_last_s) begin
                    sm_tdata_r <= out_val_s;
                    sm_tlast_r <= last_out_s;
                end
            end else if (out_fire_s) begin
                out_cnt_r  <= out_cnt_r + DATA_W'(1);
                sm_tlast_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_engine_param.sv
// -----------------------------------------------------------------------------
// tb_fir_engine_param
//   Self-checking bench for fir_engine_param (default parameters). Outputs are
//   compared with a direct convolution sum over the programmed taps and the
//   samples sent since the last start. Inputs are driven and outputs sampled
//   on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fir_engine_param;

    localparam int MAX_TAP = 16;
    localparam logic [11:0] A_CTRL = 12'h000;
    localparam logic [11:0] A_LEN  = 12'h010;
    localparam logic [11:0] A_NTAP = 12'h014;
    localparam logic [11:0] A_TAP0 = 12'h020;

    logic        clk, rst_n;
    logic        awvalid, awready, wvalid, wready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic        arvalid, arready, rvalid, rready;
    logic        ss_tvalid, ss_tready, ss_tlast;
    logic [31:0] ss_tdata;
    logic        sm_tvalid, sm_tready, sm_tlast;
    logic [31:0] sm_tdata;

    int total = 0;
    int bad   = 0;

    int tap_m [MAX_TAP];
    int ntap_m;
    int samp  [600];

    fir_engine_param #(.DATA_W(32), .ADDR_W(12), .MAX_TAP(MAX_TAP)) dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .ss_tvalid  (ss_tvalid),
        .ss_tready  (ss_tready),
        .ss_tdata   (ss_tdata),
        .ss_tlast   (ss_tlast),
        .sm_tvalid  (sm_tvalid),
        .sm_tready  (sm_tready),
        .sm_tdata   (sm_tdata),
        .sm_tlast   (sm_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // y[n] = sum over k<ntap of h[k]*x[n-k], history before the run is zero.
    function automatic logic [31:0] ref_y(input int n);
        longint acc;
        acc = 0;
        for (int k = 0; k < ntap_m; k++) begin
            if (n - k >= 0) acc += longint'(tap_m[k]) * longint'(samp[n-k]);
        end
        return acc[31:0];
    endfunction

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data);
        int n;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_value("aw_w_ready_seen", {31'd0, awready & wready}, 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] addr, output logic [31:0] data);
        int n;
        arvalid = 1'b1; araddr = addr;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_value("ar_ready_seen", {31'd0, arready}, 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_value("r_valid_seen", {31'd0, rvalid}, 32'd1);
        data = rdata;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        check_value(tag, d, exp);
    endtask

    task automatic program_cfg();
        axi_write(A_NTAP, 32'(ntap_m));
        for (int k = 0; k < ntap_m; k++) axi_write(A_TAP0 + 12'(4 * k), 32'(tap_m[k]));
    endtask

    task automatic start_run(input int len);
        axi_write(A_LEN, 32'(len));
        axi_write(A_CTRL, 32'd1);
    endtask

    // One sample in, one result out; stall cycles hold sm_tready low.
    task automatic send_and_get(input logic [31:0] din, input int stall,
                                output logic [31:0] dout, output logic lastv, output int lat);
        int n;
        logic [31:0] held;
        ss_tvalid = 1'b1; ss_tdata = din;
        n = 0;
        while (!ss_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_value("ss_tready_seen", {31'd0, ss_tready}, 32'd1);
        @(negedge clk);
        ss_tvalid = 1'b0;
        lat = 1;
        while (!sm_tvalid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        held = sm_tdata;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_value("stall_data", sm_tdata, held);
            check_value("stall_flags", {29'd0, sm_tvalid, ss_tready, 1'b0}, 32'h4);
        end
        sm_tready = 1'b1;
        dout  = sm_tdata;
        lastv = sm_tlast;
        @(negedge clk);
        sm_tready = 1'b0;
    endtask

    task automatic run_stream(input int len, input int stall_max);
        logic [31:0] d;
        logic l;
        int lat, st;
        for (int n = 0; n < len; n++) begin
            st = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
            send_and_get(samp[n], st, d, l, lat);
            check_value($sformatf("y[%0d]", n), d, ref_y(n));
            check_value($sformatf("tlast[%0d]", n), {31'd0, l}, {31'd0, n == len - 1});
            check_value($sformatf("latency[%0d]", n), 32'(lat), 32'(ntap_m + 1));
        end
    endtask

    initial begin
        logic [31:0] d;
        logic l;
        int lat;
        int base11 [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

        rst_n = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; awaddr = '0; wdata = '0;
        arvalid = 1'b0; araddr = '0; rready = 1'b0;
        ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0; sm_tready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check_value("rst_flags", {25'd0, awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast}, 32'd0);
        check_value("rst_rdata", rdata, 32'd0);
        check_value("rst_sm_tdata", sm_tdata, 32'd0);
        read_check("rst_ctrl", A_CTRL, 32'h4);
        read_check("rst_len", A_LEN, 32'd0);
        read_check("rst_ntap", A_NTAP, 32'(MAX_TAP));
        read_check("rst_tap0", A_TAP0, 32'd0);

        // Only one of awvalid / wvalid: no ready.
        awvalid = 1'b1; awaddr = A_LEN; wdata = 32'd77;
        repeat (4) begin
            @(negedge clk);
            check_value("aw_only_ready", {30'd0, awready, wready}, 32'd0);
        end
        awvalid = 1'b0; wvalid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_value("w_only_ready", {30'd0, awready, wready}, 32'd0);
        end
        wvalid = 1'b0;
        @(negedge clk);
        read_check("len_untouched", A_LEN, 32'd0);

        // Config readback and clamping
        ntap_m = 11;
        for (int k = 0; k < 11; k++) tap_m[k] = base11[k];
        axi_write(A_LEN, 32'd600);
        program_cfg();
        read_check("len_rb", A_LEN, 32'd600);
        for (int k = 0; k < 11; k++)
            read_check($sformatf("tap_rb[%0d]", k), A_TAP0 + 12'(4 * k), 32'(base11[k]));
        axi_write(A_NTAP, 32'd0);
        read_check("ntap_clamp_lo", A_NTAP, 32'd1);
        axi_write(A_NTAP, 32'd99);
        read_check("ntap_clamp_hi", A_NTAP, 32'(MAX_TAP));
        read_check("unmapped_0c", 12'h00C, 32'd0);
        read_check("unmapped_tap_end", 12'h060, 32'd0);
        axi_write(A_NTAP, 32'd11);

        // Impulse with busy lockout checks before streaming
        for (int n = 0; n < 11; n++) samp[n] = (n == 0) ? 1 : 0;
        start_run(11);
        read_check("ctrl_busy", A_CTRL, 32'h1);
        axi_write(A_TAP0, 32'd7);
        axi_write(A_LEN, 32'd5);
        axi_write(A_NTAP, 32'd3);
        read_check("busy_tap0", A_TAP0, 32'd0);
        read_check("busy_len", A_LEN, 32'd11);
        read_check("busy_ntap", A_NTAP, 32'd11);
        for (int n = 0; n < 11; n++) begin
            send_and_get(samp[n], 0, d, l, lat);
            check_value($sformatf("impulse[%0d]", n), d, 32'(base11[n]));
            check_value($sformatf("impulse_tlast[%0d]", n), {31'd0, l}, {31'd0, n == 10});
            check_value($sformatf("impulse_lat[%0d]", n), 32'(lat), 32'd12);
        end
        read_check("ctrl_done", A_CTRL, 32'h6);
        read_check("ctrl_done_clr", A_CTRL, 32'h4);

        // Golden triangle wave, three back-to-back runs
        for (int n = 0; n < 600; n++) begin
            int p, v;
            p = n % 40;
            v = (p < 20) ? p : 40 - p;
            samp[n] = (v - 10) * 37;
        end
        for (int r = 0; r < 3; r++) begin
            start_run(600);
            run_stream(600, 0);
            read_check("golden_done", A_CTRL, 32'h6);
        end

        // Random taps and samples with random output backpressure
        for (int c = 0; c < 3; c++) begin
            ntap_m = (c == 0) ? 1 : (c == 1) ? MAX_TAP : int'($urandom_range(2, MAX_TAP - 1));
            for (int k = 0; k < MAX_TAP; k++) tap_m[k] = int'($urandom_range(0, 4000)) - 2000;
            for (int n = 0; n < 40; n++) samp[n] = int'($urandom_range(0, 4000)) - 2000;
            program_cfg();
            start_run(40);
            run_stream(40, 5);
            read_check("rand_done", A_CTRL, 32'h6);
        end

        // Zero-length start: done at once, no stream activity
        start_run(0);
        repeat (4) begin
            @(negedge clk);
            check_value("zero_len_stream", {30'd0, ss_tready, sm_tvalid}, 32'd0);
        end
        read_check("zero_len_ctrl", A_CTRL, 32'h6);

        // Wide product: saturates or wraps depending on the build
        ntap_m = 1;
        tap_m[0] = 1 << 30;
        program_cfg();
        start_run(1);
        send_and_get(32'd4, 0, d, l, lat);
`ifdef FIR_SATURATE_EN
        check_value("sat_out", d, 32'h7FFF_FFFF);
`else
        check_value("wrap_out", d, 32'h0000_0000);
`endif
        check_value("sat_tlast", {31'd0, l}, 32'd1);

        // Asynchronous reset while an output is pending
        tap_m[0] = 3;
        program_cfg();
        start_run(1);
        ss_tvalid = 1'b1; ss_tdata = 32'd5;
        lat = 0;
        while (!ss_tready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        ss_tvalid = 1'b0;
        lat = 0;
        while (!sm_tvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_value("pre_rst_data", sm_tdata, 32'd15);
        check_value("pre_rst_flags", {30'd0, sm_tvalid, sm_tlast}, 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_flags", {25'd0, awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast}, 32'd0);
        check_value("mid_rst_sm_tdata", sm_tdata, 32'd0);
        check_value("mid_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sm_tready = 1'b1;
        ss_tvalid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_value("post_rst_stream", {30'd0, ss_tready, sm_tvalid}, 32'd0);
        end
        ss_tvalid = 1'b0;
        sm_tready = 1'b0;
        read_check("post_rst_ctrl", A_CTRL, 32'h4);
        read_check("post_rst_ntap", A_NTAP, 32'(MAX_TAP));
        read_check("post_rst_tap0", A_TAP0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
